cs: RTL and testbench

Sliding-window "approximate average" filter. Each clock it takes an 8-bit sample into a 9-deep window. It finds the largest windowed sample that does not exceed the integer average of the window. It outputs a 10-bit smoothed value built from that sample and the window sum. It sits in a streaming datapath between a sample source and a consumer that samples `Y` on rising `clk`.

---
 rtl/cs.sv | 75 +++++++
 tb/tb_cs.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cs.sv
// cs: 9-deep sliding-window approximate-average filter (8-bit samples, 10-bit output).
// Optional output register selected by defining CS_OUTREG_EN; default build drives Y combinationally.
module cs (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] X,
    output logic [9:0] Y
);

    localparam int DEPTH = 9;

    logic [7:0]  win_p0 [DEPTH];
    logic [11:0] sum;
    logic [11:0] avg;
    logic [7:0]  xappr;
    logic [12:0] total;
    logic [9:0]  y_next;

    function automatic logic [11:0] div9(input logic [11:0] v);
        return v / 12'd9;
    endfunction

    function automatic logic [9:0] floor_div8(input logic [12:0] v);
        return 10'(v >> 3);
    endfunction

    // Stage p0: window shift register, newest sample in slot 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_p0[i] <= '0;
            end
        end else begin
            win_p0[0] <= X;
            for (int i = 1; i < DEPTH; i++) begin
                win_p0[i] <= win_p0[i-1];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = sum + {4'b0000, win_p0[i]};
        end
        avg = div9(sum);
        // Starting from 0 is safe: the window minimum never exceeds the average.
        xappr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({4'b0000, win_p0[i]} <= avg) && (win_p0[i] > xappr)) begin
                xappr = win_p0[i];
            end
        end
        total  = 13'(sum) + 13'(xappr) * 13'd9;
        y_next = floor_div8(total);
    end

`ifdef CS_OUTREG_EN
    logic [9:0] y_p1;

    // Stage p1: registered output, one extra cycle of latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= y_next;
        end
    end

    assign Y = y_p1;
`else
    assign Y = y_next;
`endif

endmodule

// File: tb/tb_cs.sv
// Self-checking bench for cs: directed window patterns, async reset, and randomized streaming
// against a queue-based reference of the windowed approximate average.
module tb_cs;

    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;

    int n_checks = 0;
    int n_errors = 0;

    int    win_q[$];
    int    exp_y;
    int    y_reg_m;
    int    pend_c;
    string pend_tag;

    cs dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Reference: average, best sample not above it, then the smoothed result.
    function automatic int model_y();
        int s, a, best;
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        a = s / 9;
        best = -1;
        foreach (win_q[i]) if (win_q[i] <= a && win_q[i] > best) best = win_q[i];
        return (s + 9 * best) / 8;
    endfunction

    task automatic clear_model();
        win_q.delete();
        for (int i = 0; i < 9; i++) win_q.push_back(0);
        y_reg_m  = 0;
        exp_y    = 0;
        pend_c   = -1;
        pend_tag = "";
    endtask

    // Called at a falling edge: drive a sample, let it register, check at the next falling edge.
    task automatic step(input int v, input string tag, input int c);
        int    dc;
        string dt;
        X = 8'(v);
        @(posedge clk);
`ifdef CS_OUTREG_EN
        y_reg_m = model_y();
        win_q.push_front(v);
        void'(win_q.pop_back());
        exp_y = y_reg_m;
        dc = pend_c;
        dt = pend_tag;
        pend_c = c;
        pend_tag = tag;
`else
        win_q.push_front(v);
        void'(win_q.pop_back());
        exp_y = model_y();
        dc = c;
        dt = tag;
`endif
        @(negedge clk);
        check("model", int'(Y), exp_y);
        if (dc >= 0) check(dt, int'(Y), dc);
    endtask

    task automatic fill(input int v, input int n);
        for (int i = 0; i < n; i++) step(v, "", -1);
    endtask

    initial begin
        reset = 1'b0;
        X     = '0;
        clear_model();
        #1;
        check("reset_state", int'(Y), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        fill(10, 8);
        step(10, "const10", 22);

        for (int v = 1; v <= 8; v++) step(v, "", -1);
        step(9, "ramp", 11);
        step(10, "slide", 13);

        fill(0, 8);
        step(255, "outlier", 31);
        step(0, "outlier_next", 31);

        fill(255, 8);
        step(255, "full_scale", 573);
        step(7, "", -1);

        // Asynchronous reset mid-stream with a non-zero window
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", int'(Y), 0);
        clear_model();
        X = 8'd200;
        @(posedge clk);
        #1;
        check("rst_hold", int'(Y), 0);
        @(negedge clk);
        reset = 1'b1;
        step(100, "refill", -1);

        for (int i = 0; i < 400; i++) begin
            int r, v;
            r = $urandom_range(0, 9);
            if (r == 0)      v = 0;
            else if (r == 1) v = 255;
            else if (r < 5)  v = $urandom_range(0, 15);
            else             v = $urandom_range(0, 255);
            step(v, "", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, limit %0d ns", 200000);
        $fatal(1);
    end

endmodule
